// File: rtl/trap_if.sv
// Fetch-side inputs and trap redirect/CSR outputs of the trap controller.
interface trap_if #(
    parameter int unsigned N = 64
);
    logic [3:0]   exceptSignal_F;
    logic [N-1:0] PC_F;
    logic         valid_F;
    logic         stall;
    logic         flush_in;
    logic         mret;
    logic [N-1:0] mtvec;
    logic         trap_take;
    logic [N-1:0] trap_PC;
    logic         flush_out;
    logic         busy;
    logic [N-1:0] mepc;
    logic [N-1:0] mtval;
    logic [N-1:0] mcause;

    modport master (
        output exceptSignal_F, PC_F, valid_F, stall, flush_in, mret, mtvec,
        input  trap_take, trap_PC, flush_out, busy, mepc, mtval, mcause
    );

    modport slave (
        input  exceptSignal_F, PC_F, valid_F, stall, flush_in, mret, mtvec,
        output trap_take, trap_PC, flush_out, busy, mepc, mtval, mcause
    );
endinterface

// File: rtl/trap_ctrl.sv
// Trap controller: tracks fetch exceptions down to commit (D/E/M), then
// flushes the pipeline, captures mepc/mtval/mcause and redirects to mtvec.
module trap_ctrl #(
    parameter int unsigned N = 64
) (
    input logic   clk,
    input logic   reset,
    trap_if.slave bus
);
    typedef struct packed {
        logic         valid;
        logic [3:0]   exc;
        logic [N-1:0] pc;
    } stage_t;

    typedef enum logic [1:0] {IDLE, FLUSH, REDIRECT, RET} state_t;

    state_t state, state_nx;
    stage_t st_d, st_e, st_m;
    stage_t d_nx, e_nx, m_nx;
    logic   qualify_c;
    logic   busy_c;

    // Breakpoint beats page fault beats access fault beats misalign (code 0).
    function automatic logic [N-1:0] cause_code(input logic [3:0] exc);
        logic [N-1:0] code;
        code = '0;
        if (exc[3])      code = N'(3);
        else if (exc[2]) code = N'(12);
        else if (exc[1]) code = N'(1);
        return code;
    endfunction

    assign qualify_c = st_m.valid && (|st_m.exc) && !bus.stall;
    assign busy_c    = (state == FLUSH) || (state == REDIRECT);

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    // Next state and state-decoded outputs; stall only matters in IDLE.
    always_comb begin
        state_nx      = state;
        bus.flush_out = 1'b0;
        bus.trap_take = 1'b0;
        bus.busy      = 1'b0;
        bus.trap_PC   = '0;
        unique case (state)
            IDLE: begin
                if (qualify_c)     state_nx = FLUSH;
                else if (bus.mret) state_nx = RET;
            end
            FLUSH: begin
                bus.flush_out = 1'b1;
                bus.busy      = 1'b1;
                state_nx      = REDIRECT;
            end
            REDIRECT: begin
                bus.trap_take = 1'b1;
                bus.busy      = 1'b1;
                bus.trap_PC   = {bus.mtvec[N-1:2], 2'b00};
                state_nx      = IDLE;
            end
            RET: begin
                bus.trap_take = 1'b1;
                bus.trap_PC   = bus.mepc;
                state_nx      = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Tracking-stage next values; a branch flush also kills what E hands to M.
    always_comb begin
        d_nx = st_d;
        e_nx = st_e;
        m_nx = st_m;
        if (!bus.stall) begin
            d_nx       = {bus.valid_F & ~busy_c, bus.exceptSignal_F, bus.PC_F};
            e_nx       = st_d;
            m_nx       = st_e;
            m_nx.valid = st_e.valid & ~bus.flush_in;
        end
        d_nx.valid = d_nx.valid & ~bus.flush_in;
        e_nx.valid = e_nx.valid & ~bus.flush_in;
        if (state == FLUSH) begin
            d_nx.valid = 1'b0;
            e_nx.valid = 1'b0;
            m_nx.valid = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            st_d <= '0;
            st_e <= '0;
            st_m <= '0;
        end else begin
            st_d <= d_nx;
            st_e <= e_nx;
            st_m <= m_nx;
        end
    end

    // Trap CSRs are written only on trap entry.
    always_ff @(posedge clk) begin
        if (!reset) begin
            bus.mepc   <= '0;
            bus.mtval  <= '0;
            bus.mcause <= '0;
        end else if (state == IDLE && qualify_c) begin
            bus.mepc   <= st_m.pc;
            bus.mtval  <= st_m.pc;
            bus.mcause <= cause_code(st_m.exc);
        end
    end
endmodule

// File: tb/tb_trap_ctrl.sv
// Bench for trap_ctrl: directed vector table, corner-case sequences and
// random traffic, all cross-checked against a schedule-based reference model.
module tb_trap_ctrl;
    localparam int unsigned N = 64;
    localparam int PH_IDLE = 0, PH_FLUSH = 1, PH_REDIR = 2, PH_RET = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    trap_if #(.N(N)) bus();
    trap_ctrl #(.N(N)) dut (.clk(clk), .reset(reset), .bus(bus));

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic         v;
        logic [3:0]   x;
        logic [N-1:0] pc;
    } ent_t;

    typedef struct {
        int rst, vld, exc, pc, mret;
        int e_take, e_flush, e_busy, e_tpc, e_cause, e_mepc;
    } vec_t;

    // Reference model: instruction slots to commit plus a schedule of phases.
    ent_t         pipe[3];
    int           cur = PH_IDLE;
    int           fut[$];
    logic [N-1:0] m_mepc, m_cause;

    task automatic check(string name, logic [N-1:0] act, logic [N-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [N-1:0] cause_of(logic [3:0] x);
        int order[4] = '{3, 2, 1, 0};
        int code[4]  = '{3, 12, 1, 0};
        for (int i = 0; i < 4; i++)
            if (x[order[i]]) return N'(code[i]);
        return '0;
    endfunction

    task automatic model_edge();
        ent_t nx[3];
        logic busy_m, qual;
        if (!reset) begin
            foreach (pipe[i]) pipe[i].v = 1'b0;
            cur = PH_IDLE;
            fut.delete();
            m_mepc  = '0;
            m_cause = '0;
            return;
        end
        busy_m = (cur == PH_FLUSH) || (cur == PH_REDIR);
        qual   = (cur == PH_IDLE) && pipe[2].v && (pipe[2].x != 4'b0) && !bus.stall;
        nx = pipe;
        if (!bus.stall) begin
            for (int i = 2; i > 0; i--) nx[i] = pipe[i-1];
            nx[0].v  = bus.valid_F & ~busy_m;
            nx[0].x  = bus.exceptSignal_F;
            nx[0].pc = bus.PC_F;
        end
        if (bus.flush_in) begin
            nx[0].v = 1'b0;
            nx[1].v = 1'b0;
            if (!bus.stall) nx[2].v = 1'b0;
        end
        if (cur == PH_FLUSH) foreach (nx[i]) nx[i].v = 1'b0;
        if (cur != PH_IDLE) begin
            if (fut.size() != 0) cur = fut.pop_front();
            else                 cur = PH_IDLE;
        end else if (qual) begin
            cur = PH_FLUSH;
            fut.push_back(PH_REDIR);
            m_mepc  = pipe[2].pc;
            m_cause = cause_of(pipe[2].x);
        end else if (bus.mret) begin
            cur = PH_RET;
        end
        pipe = nx;
    endtask

    task automatic model_check();
        logic et;
        et = (cur == PH_REDIR) || (cur == PH_RET);
        check("model.trap_take", N'(bus.trap_take), N'(et));
        check("model.flush_out", N'(bus.flush_out), N'(cur == PH_FLUSH));
        check("model.busy", N'(bus.busy), N'((cur == PH_FLUSH) || (cur == PH_REDIR)));
        if (et)
            check("model.trap_PC", bus.trap_PC,
                  (cur == PH_REDIR) ? {bus.mtvec[N-1:2], 2'b00} : m_mepc);
        check("model.mepc", bus.mepc, m_mepc);
        check("model.mtval", bus.mtval, m_mepc);
        check("model.mcause", bus.mcause, m_cause);
    endtask

    task automatic set_in(int rst, int vld, int exc, int pc, int stl, int fl, int mr);
        reset              = 1'(rst);
        bus.valid_F        = 1'(vld);
        bus.exceptSignal_F = 4'(exc);
        bus.PC_F           = N'(pc);
        bus.stall          = 1'(stl);
        bus.flush_in       = 1'(fl);
        bus.mret           = 1'(mr);
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        model_check();
    endtask

    function automatic vec_t mk(int rst, int vld, int exc, int pc, int mr,
                                int tk, int fo, int bz, int tpc, int cs, int ep);
        vec_t v;
        v.rst = rst; v.vld = vld; v.exc = exc; v.pc = pc; v.mret = mr;
        v.e_take = tk; v.e_flush = fo; v.e_busy = bz;
        v.e_tpc = tpc; v.e_cause = cs; v.e_mepc = ep;
        return v;
    endfunction

    vec_t tbl[$];

    initial begin
        // rst vld exc pc mret | take flush busy trap_PC mcause mepc
        tbl.push_back(mk(0, 0, 0, 0,       0,  0, 0, 0, 0,       0, 0));
        tbl.push_back(mk(1, 1, 1, 'h1002,  0,  0, 0, 0, 0,       0, 0));
        tbl.push_back(mk(1, 0, 0, 0,       0,  0, 0, 0, 0,       0, 0));
        tbl.push_back(mk(1, 0, 0, 0,       0,  0, 0, 0, 0,       0, 0));
        tbl.push_back(mk(1, 0, 0, 0,       0,  0, 1, 1, 0,       0, 'h1002));
        tbl.push_back(mk(1, 0, 0, 0,       0,  1, 0, 1, 'h8000,  0, 'h1002));
        tbl.push_back(mk(1, 0, 0, 0,       0,  0, 0, 0, 0,       0, 'h1002));
        tbl.push_back(mk(1, 1, 15, 'h2000, 0,  0, 0, 0, 0,       0, 'h1002));
        tbl.push_back(mk(1, 0, 0, 0,       0,  0, 0, 0, 0,       0, 'h1002));
        tbl.push_back(mk(1, 0, 0, 0,       0,  0, 0, 0, 0,       0, 'h1002));
        tbl.push_back(mk(1, 0, 0, 0,       0,  0, 1, 1, 0,       3, 'h2000));
        tbl.push_back(mk(1, 0, 0, 0,       0,  1, 0, 1, 'h8000,  3, 'h2000));
        tbl.push_back(mk(1, 0, 0, 0,       0,  0, 0, 0, 0,       3, 'h2000));
        tbl.push_back(mk(1, 0, 0, 0,       1,  1, 0, 0, 'h2000,  3, 'h2000));
        tbl.push_back(mk(1, 0, 0, 0,       0,  0, 0, 0, 0,       3, 'h2000));

        bus.mtvec = N'(64'h8001);
        foreach (tbl[i]) begin
            set_in(tbl[i].rst, tbl[i].vld, tbl[i].exc, tbl[i].pc, 0, 0, tbl[i].mret);
            tick();
            check($sformatf("vec%0d.take", i), N'(bus.trap_take), N'(tbl[i].e_take));
            check($sformatf("vec%0d.flush", i), N'(bus.flush_out), N'(tbl[i].e_flush));
            check($sformatf("vec%0d.busy", i), N'(bus.busy), N'(tbl[i].e_busy));
            if (tbl[i].e_take != 0 || tbl[i].rst == 0)
                check($sformatf("vec%0d.trap_PC", i), bus.trap_PC, N'(tbl[i].e_tpc));
            check($sformatf("vec%0d.mcause", i), bus.mcause, N'(tbl[i].e_cause));
            check($sformatf("vec%0d.mepc", i), bus.mepc, N'(tbl[i].e_mepc));
            check($sformatf("vec%0d.mtval", i), bus.mtval, N'(tbl[i].e_mepc));
        end

        // Branch flush while the faulting entry sits in E: it never commits.
        set_in(1, 1, 2, 'h3000, 0, 0, 0); tick();
        set_in(1, 0, 0, 0, 0, 0, 0);      tick();
        set_in(1, 0, 0, 0, 0, 1, 0);      tick();
        set_in(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("killed.flush_out", N'(bus.flush_out), N'(0));
            check("killed.trap_take", N'(bus.trap_take), N'(0));
        end
        check("killed.mcause", bus.mcause, N'(3));

        // Stall holds a qualified exception; mret on the releasing cycle loses.
        set_in(1, 1, 4, 'h4000, 0, 0, 0); tick();
        set_in(1, 0, 0, 0, 0, 0, 0);      tick(); tick();
        set_in(1, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("stall.flush_out", N'(bus.flush_out), N'(0));
        end
        set_in(1, 0, 0, 0, 0, 0, 1); tick();
        check("stall.flush_after", N'(bus.flush_out), N'(1));
        check("stall.mcause", bus.mcause, N'(12));
        tick();
        check("stall.take", N'(bus.trap_take), N'(1));
        check("stall.trap_PC", bus.trap_PC, N'(64'h8000));
        tick();
        check("stall.no_ret", N'(bus.trap_take), N'(0));

        // Reset in FLUSH aborts the trap sequence.
        set_in(1, 1, 8, 'h5000, 0, 0, 0); tick();
        set_in(1, 0, 0, 0, 0, 0, 0);      tick(); tick(); tick();
        check("rst.in_flush", N'(bus.flush_out), N'(1));
        set_in(0, 0, 0, 0, 0, 0, 0); tick();
        check("rst.flush_out", N'(bus.flush_out), N'(0));
        check("rst.busy", N'(bus.busy), N'(0));
        check("rst.trap_PC", bus.trap_PC, N'(0));
        check("rst.mepc", bus.mepc, N'(0));
        check("rst.mcause", bus.mcause, N'(0));
        set_in(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst.no_take", N'(bus.trap_take), N'(0));
        end

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            int r_rst, r_vld, r_exc, r_stl, r_fl, r_mr;
            r_rst = ($urandom_range(0, 49) != 0) ? 1 : 0;
            r_vld = ($urandom_range(0, 1) != 0) ? 1 : 0;
            r_exc = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 15)) : 0;
            r_stl = ($urandom_range(0, 4) == 0) ? 1 : 0;
            r_fl  = ($urandom_range(0, 9) == 0) ? 1 : 0;
            r_mr  = ($urandom_range(0, 7) == 0) ? 1 : 0;
            bus.mtvec = {$urandom(), $urandom()};
            set_in(r_rst, r_vld, r_exc, int'($urandom()), r_stl, r_fl, r_mr);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/trap_ctrl.md
TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 Parameter N, default 64, datapath/PC width in bits.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-low reset.
REQ-004 exceptSignal_F  in  4  fetch exception vector {breakpoint, page fault, access fault, misalign}.
REQ-005 PC_F  in  N  PC of the instruction currently in fetch.
REQ-006 valid_F  in  1  fetch instruction valid.
REQ-007 stall  in  1  pipeline hold; tracking stages keep contents.
REQ-008 flush_in  in  1  external (branch) flush of younger stages D and E.
REQ-009 mret  in  1  return-from-trap request, one cycle.
REQ-010 mtvec  in  N  trap vector base.
REQ-011 trap_take  out  1  one-cycle PC redirect strobe.
REQ-012 trap_PC  out  N  redirect target, valid when trap_take=1.
REQ-013 flush_out  out  1  flush entire pipeline.
REQ-014 busy  out  1  trap sequence in progress.
REQ-015 mepc, mtval  out  N each  captured faulting PC.
REQ-016 mcause  out  N  captured cause code.

Function
REQ-017 Three tracking stages D, E, M SHALL each hold {valid, except[3:0], pc[N-1:0]}, matching pipeline depth to commit.
REQ-018 When stall=0, contents SHALL shift F->D->E->M each cycle; D loads {valid_F & ~busy, exceptSignal_F, PC_F}.
REQ-019 When stall=1, D/E/M SHALL hold.
REQ-020 flush_in=1 SHALL clear valid of D and E (and of the D/E values being loaded that cycle); M unaffected.
REQ-021 FSM states: IDLE, FLUSH, REDIRECT, RET.
REQ-022 IDLE -> FLUSH when M.valid=1, |M.except=1, stall=0; same edge captures mepc=M.pc, mtval=M.pc, mcause per REQ-023.
REQ-023 Cause priority/encoding (zero-extended to N): breakpoint=3 > page fault=12 > access fault=1 > misalign=0.
REQ-024 FLUSH: flush_out=1 for exactly one cycle; all D/E/M valid cleared at end of cycle; -> REDIRECT unconditionally.
REQ-025 REDIRECT: trap_take=1, trap_PC={mtvec[N-1:2],2'b00}; -> IDLE.
REQ-026 IDLE with mret=1 and no qualifying exception SHALL -> RET; RET: trap_take=1, trap_PC=mepc; -> IDLE.
REQ-027 Exception qualifying in same cycle as mret SHALL win; mret dropped.
REQ-028 mret in any state other than IDLE SHALL be ignored.
REQ-029 busy=1 in FLUSH and REDIRECT, 0 otherwise; FLUSH/REDIRECT/RET ignore stall.
REQ-030 Exception in M with stall=1 SHALL wait (no transition) until stall=0.
REQ-031 flush_out, trap_take SHALL be registered-state decodes, never asserted in IDLE.
REQ-032 mepc/mcause/mtval SHALL change only on the IDLE->FLUSH edge or reset.
REQ-033 Trap entry latency: M qualifies at cycle t -> flush_out at t+1 -> trap_take at t+2.

Reset
REQ-034 reset=0 at a clock edge SHALL force IDLE, clear all stage valids, mepc=mcause=mtval=0, trap_take=flush_out=busy=0, trap_PC=0.
REQ-035 Reset asserted mid-sequence (FLUSH/REDIRECT/RET) SHALL abort it; no trap_take follows reset release.

Verification
REQ-036 PC_F=0x1002, valid_F=1, except=0001, no stall -> 3 cycles later FLUSH; mcause=0, mepc=mtval=0x1002; next cycle trap_take=1, trap_PC=mtvec&~3 (mtvec=0x8001 -> 0x8000).
REQ-037 except=1111 at PC 0x2000 -> mcause=3 (breakpoint priority), mepc=0x2000.
REQ-038 except=0010 at PC 0x3000, flush_in=1 while entry in E -> no FLUSH, no trap_take, mcause unchanged.
REQ-039 Exception in M with stall=1 for 4 cycles -> flush_out only on cycle after stall drops; mret asserted same cycle as qualification -> ignored, trap_PC=mtvec.
REQ-040 After trap with mepc=0x2000, mret=1 in IDLE -> next cycle trap_take=1, trap_PC=0x2000; reset=0 during FLUSH -> IDLE, all outputs 0, no subsequent trap_take.
